// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM state and instruction layout.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int OP_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Instruction word is {op, rd, rs, rt}, rt in the least significant bits.
    function automatic int instr_w(input int raw);
        return OP_W + 3 * raw;
    endfunction

    function automatic int rt_lsb(input int raw);
        return 0 * raw;
    endfunction

    function automatic int rs_lsb(input int raw);
        return raw;
    endfunction

    function automatic int rd_lsb(input int raw);
        return 2 * raw;
    endfunction

    function automatic int op_lsb(input int raw);
        return 3 * raw;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file for the issue stage: writeback and load write ports, three combinational reads.
module alu_regfile #(
    parameter int DW  = 5,
    parameter int RAW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wb_en,
    input  logic [RAW-1:0] wb_addr,
    input  logic [DW-1:0]  wb_data,
    input  logic           ld_en,
    input  logic [RAW-1:0] ld_addr,
    input  logic [DW-1:0]  ld_data,
    input  logic [RAW-1:0] rs_addr,
    input  logic [RAW-1:0] rt_addr,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  rs_data,
    output logic [DW-1:0]  rt_data,
    output logic [DW-1:0]  dbg_data
);

    localparam int NREGS = 2 ** RAW;

    logic [DW-1:0] regs [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DW-1:0] q_reg;

            // Writeback has priority when both ports target the same register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (wb_en && (wb_addr == RAW'(gi))) begin
                    q_reg <= wb_data;
                end else if (ld_en && (ld_addr == RAW'(gi))) begin
                    q_reg <= ld_data;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rs_data  = regs[rs_addr];
    assign rt_data  = regs[rt_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding a combinational ALU; two-state issue/execute FSM with writeback and status.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW   = 5,
    parameter int RAW  = 2,
    parameter int CNTW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [OP_W+3*RAW-1:0] instr,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [RAW-1:0]        ld_addr,
    input  logic [DW-1:0]         ld_data,
    output logic [DW-1:0]         alu_a,
    output logic [DW-1:0]         alu_b,
    output logic [1:0]            alu_ctrl,
    input  logic [2*DW-1:0]       alu_result,
    input  logic                  alu_zflag,
    output logic                  wb_valid,
    output logic [RAW-1:0]        wb_addr,
    output logic [DW-1:0]         wb_data,
    output logic                  z_flag,
    output logic                  ovf_flag,
    output logic [CNTW-1:0]       retired,
    input  logic [RAW-1:0]        dbg_addr,
    output logic [DW-1:0]         dbg_data
);

    localparam int RT_LSB = rt_lsb(RAW);
    localparam int RS_LSB = rs_lsb(RAW);
    localparam int RD_LSB = rd_lsb(RAW);
    localparam int OP_LSB = op_lsb(RAW);

    state_t          state_reg;
    logic [RAW-1:0]  rd_reg;
    logic [DW-1:0]   alu_a_reg;
    logic [DW-1:0]   alu_b_reg;
    logic [1:0]      alu_ctrl_reg;
    logic            wb_valid_reg;
    logic [RAW-1:0]  wb_addr_reg;
    logic [DW-1:0]   wb_data_reg;
    logic            z_flag_reg;
    logic            ovf_flag_reg;
    logic [CNTW-1:0] retired_reg;

    logic [1:0]      instr_op;
    logic [RAW-1:0]  instr_rd;
    logic [RAW-1:0]  instr_rs;
    logic [RAW-1:0]  instr_rt;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic            issue_fire;
    logic            ld_fire;
    logic            exec_done;
    logic [DW-1:0]   result_low;
    logic            result_ovf;

    assign instr_op = instr[OP_LSB +: OP_W];
    assign instr_rd = instr[RD_LSB +: RAW];
    assign instr_rs = instr[RS_LSB +: RAW];
    assign instr_rt = instr[RT_LSB +: RAW];

    // A pending load always beats a new instruction while idle.
    assign instr_ready = (state_reg == IDLE) && !ld_valid;
    assign ld_ready    = (state_reg == IDLE) || (ld_addr != rd_reg);
    assign issue_fire  = instr_valid && instr_ready;
    assign ld_fire     = ld_valid && ld_ready;
    assign exec_done   = (state_reg == EXEC);
    assign result_low  = alu_result[DW-1:0];
    assign result_ovf  = |alu_result[2*DW-1:DW];

    alu_regfile #(
        .DW  (DW),
        .RAW (RAW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (exec_done),
        .wb_addr  (rd_reg),
        .wb_data  (result_low),
        .ld_en    (ld_fire),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rs_addr  (instr_rs),
        .rt_addr  (instr_rt),
        .dbg_addr (dbg_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rd_reg       <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_ctrl_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_fire) begin
                        alu_a_reg    <= rs_data;
                        alu_b_reg    <= rt_data;
                        alu_ctrl_reg <= instr_op;
                        rd_reg       <= instr_rd;
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Retirement status; wb_valid is a single-cycle pulse following the execute edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
            z_flag_reg   <= 1'b0;
            ovf_flag_reg <= 1'b0;
            retired_reg  <= '0;
        end else begin
            wb_valid_reg <= exec_done;
            if (exec_done) begin
                wb_addr_reg  <= rd_reg;
                wb_data_reg  <= result_low;
                z_flag_reg   <= alu_zflag;
                ovf_flag_reg <= ovf_flag_reg | result_ovf;
                retired_reg  <= retired_reg + 1'b1;
            end
        end
    end

    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_ctrl = alu_ctrl_reg;
    assign wb_valid = wb_valid_reg;
    assign wb_addr  = wb_addr_reg;
    assign wb_data  = wb_data_reg;
    assign z_flag   = z_flag_reg;
    assign ovf_flag = ovf_flag_reg;
    assign retired  = retired_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 5-bit ALU closing the loop.
module tb_alu_issue_stage;

    localparam int DW   = 5;
    localparam int RAW  = 2;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [7:0]      instr;
    logic            ld_valid;
    logic            ld_ready;
    logic [RAW-1:0]  ld_addr;
    logic [DW-1:0]   ld_data;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [1:0]      alu_ctrl;
    logic [2*DW-1:0] alu_result;
    logic            alu_zflag;
    logic            wb_valid;
    logic [RAW-1:0]  wb_addr;
    logic [DW-1:0]   wb_data;
    logic            z_flag;
    logic            ovf_flag;
    logic [CNTW-1:0] retired;
    logic [RAW-1:0]  dbg_addr;
    logic [DW-1:0]   dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DW(DW), .RAW(RAW), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zflag   (alu_zflag),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .z_flag      (z_flag),
        .ovf_flag    (ovf_flag),
        .retired     (retired),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Downstream ALU: operands zero-extended to 10 bits, subtraction wraps in 10 bits.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            2'b00: alu_result = {5'b0, alu_a & alu_b};
            2'b01: alu_result = {5'b0, alu_a ^ alu_b};
            2'b10: alu_result = {5'b0, alu_a} + {5'b0, alu_b};
            default: alu_result = {5'b0, alu_a} - {5'b0, alu_b};
        endcase
    end
    assign alu_zflag = (alu_a == alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic peek(input string tag, input logic [RAW-1:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_load(input logic [RAW-1:0] a, input logic [DW-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic do_issue(input logic [1:0] op, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [1:0] rt);
        instr_valid = 1'b1;
        instr       = {op, rd, rs, rt};
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;

        // 1: reset state and a basic add
        @(negedge clk);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_ctrl", 32'(alu_ctrl), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_ovf", 32'(ovf_flag), 0);
        chk("rst_ready", 32'(instr_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(2'd1, 5'd5);
        do_load(2'd2, 5'd3);
        do_issue(2'b10, 2'd0, 2'd1, 2'd2);
        chk("add_alu_a", 32'(alu_a), 5);
        chk("add_alu_b", 32'(alu_b), 3);
        chk("add_ctrl", 32'(alu_ctrl), 2);
        chk("exec_ready", 32'(instr_ready), 0);
        @(negedge clk);
        chk("add_wb_valid", 32'(wb_valid), 1);
        chk("add_wb_addr", 32'(wb_addr), 0);
        chk("add_wb_data", 32'(wb_data), 8);
        chk("add_retired", 32'(retired), 1);
        peek("add_r0", 2'd0, 5'd8);
        @(negedge clk);
        chk("wb_pulse_end", 32'(wb_valid), 0);

        // 2: subtraction wraps and sets sticky overflow
        do_load(2'd1, 5'd3);
        do_load(2'd2, 5'd5);
        do_issue(2'b11, 2'd0, 2'd1, 2'd2);
        chk("sub_result", 32'(alu_result), 32'h3FE);
        @(negedge clk);
        chk("sub_wb_data", 32'(wb_data), 32'h1E);
        chk("sub_ovf", 32'(ovf_flag), 1);
        chk("sub_retired", 32'(retired), 2);

        // 3: equal operands set z_flag, then clear it
        do_load(2'd1, 5'd7);
        do_load(2'd2, 5'd7);
        do_issue(2'b01, 2'd3, 2'd1, 2'd2);
        @(negedge clk);
        chk("xor_wb_data", 32'(wb_data), 0);
        chk("xor_wb_addr", 32'(wb_addr), 3);
        chk("xor_z", 32'(z_flag), 1);
        do_load(2'd2, 5'd1);
        do_issue(2'b00, 2'd3, 2'd1, 2'd2);
        @(negedge clk);
        chk("and_wb_data", 32'(wb_data), 1);
        chk("and_z", 32'(z_flag), 0);
        chk("ovf_sticky", 32'(ovf_flag), 1);
        chk("and_retired", 32'(retired), 4);

        // 4: instr_valid held high across two instructions
        instr_valid = 1'b1;
        instr       = {2'b10, 2'd0, 2'd1, 2'd2};
        @(negedge clk);
        chk("bp_ready_exec", 32'(instr_ready), 0);
        @(negedge clk);
        chk("bp_wb1", 32'(wb_valid), 1);
        chk("bp_ready_idle", 32'(instr_ready), 1);
        chk("bp_retired1", 32'(retired), 5);
        @(negedge clk);
        chk("bp_gap", 32'(wb_valid), 0);
        chk("bp_retired_gap", 32'(retired), 5);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("bp_wb2", 32'(wb_data), 8);
        chk("bp_retired2", 32'(retired), 6);

        // 5: load to the in-flight rd stalls; other rd passes
        do_issue(2'b10, 2'd0, 2'd1, 2'd2);
        ld_valid = 1'b1;
        ld_addr  = 2'd3;
        ld_data  = 5'h15;
        #1;
        chk("ld_other_rd", 32'(ld_ready), 1);
        ld_addr = 2'd0;
        #1;
        chk("ld_stall", 32'(ld_ready), 0);
        @(negedge clk);
        chk("conf_wb_data", 32'(wb_data), 8);
        chk("ld_after_wb", 32'(ld_ready), 1);
        @(negedge clk);
        ld_valid = 1'b0;
        peek("ld_persist", 2'd0, 5'h15);
        chk("conf_retired", 32'(retired), 7);

        // Load and instruction together while idle: load goes first
        ld_valid    = 1'b1;
        ld_addr     = 2'd1;
        ld_data     = 5'd2;
        instr_valid = 1'b1;
        instr       = {2'b10, 2'd0, 2'd1, 2'd2};
        #1;
        chk("both_instr_rdy", 32'(instr_ready), 0);
        chk("both_ld_rdy", 32'(ld_ready), 1);
        @(negedge clk);
        ld_valid = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("both_alu_a", 32'(alu_a), 2);
        @(negedge clk);
        chk("both_wb_data", 32'(wb_data), 3);
        chk("both_retired", 32'(retired), 8);

        // 6: asynchronous reset during EXEC aborts the op
        do_issue(2'b10, 2'd3, 2'd1, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_retired", 32'(retired), 0);
        chk("abort_ovf", 32'(ovf_flag), 0);
        peek("abort_r1", 2'd1, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_wb_valid", 32'(wb_valid), 0);
        chk("abort_retired2", 32'(retired), 0);
        peek("abort_r3", 2'd3, 5'd0);

        // retired wraps after 2**CNTW instructions
        for (int i = 0; i < 255; i++) begin
            do_issue(2'b10, 2'd0, 2'd1, 2'd2);
            @(negedge clk);
        end
        chk("wrap_pre", 32'(retired), 32'hFF);
        do_issue(2'b10, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        chk("wrap_zero", 32'(retired), 0);
        chk("wrap_wb_valid", 32'(wb_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
